king_locator_fsm: RTL



---
 rtl/chesstypes.sv | 39 +++
 rtl/king_square_match.sv | 14 +
 rtl/king_locator_fsm.sv | 137 +++++++++++++
 3 files changed

// File: rtl/chesstypes.sv
// Shared chess board types plus the state encoding of the king locator.
package chesstypes;

  localparam int NUM_SQUARES = 64;
  localparam int SQ_W        = 6;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } color_t;

  typedef struct packed {
    color_t color;
    piece_t piece;
  } fullpiece_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } kingloc_state_t;

  // True when the square holds a king of the requested colour.
  function automatic logic is_king_of(input fullpiece_t sq, input color_t c);
    return (sq.piece == KING) && (sq.color == c);
  endfunction

endpackage

// File: rtl/king_square_match.sv
// Single-square probe: does the selected square hold a king of the given colour.
module king_square_match
  import chesstypes::*;
(
  input  fullpiece_t [NUM_SQUARES-1:0] board_i,
  input  logic       [SQ_W-1:0]        index_i,
  input  color_t                       color_i,
  output logic                         match_o
);

  // One mux into the board plus a compare; shared by hint probe and scan.
  assign match_o = is_king_of(board_i[index_i], color_i);

endmodule

// File: rtl/king_locator_fsm.sv
// Locates the king of a requested colour, one square per cycle, optionally
// trying a hint square first. Reports position and a multiple-king flag.
//
// state | meaning
// IDLE  | waiting for start
// PROBE | checking the latched hint square
// SCAN  | linear walk over squares 0..63, no early exit
// DONE  | one-cycle completion pulse; accepts a new start
module king_locator_fsm
  import chesstypes::*;
#(
  parameter bit HINT_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  fullpiece_t [NUM_SQUARES-1:0] board,
  input  color_t                       color,
  input  logic       [SQ_W-1:0]        hint_pos,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic       [SQ_W-1:0]        king_pos,
  output logic                         multi
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_PROBE = PROBE;
  localparam logic [1:0] ST_SCAN  = SCAN;
  localparam logic [1:0] ST_DONE  = DONE;

  localparam logic [SQ_W-1:0] LAST_IDX = SQ_W'(NUM_SQUARES - 1);

  logic [1:0]      state_q, state_d;
  logic [SQ_W-1:0] idx_q,   idx_d;
  color_t          color_q, color_d;
  logic [SQ_W-1:0] hint_q,  hint_d;
  logic            found_q, found_d;
  logic [SQ_W-1:0] pos_q,   pos_d;
  logic            multi_q, multi_d;

  logic [SQ_W-1:0] probe_idx;
  logic            sq_match;

  // The single matcher looks at the hint while probing, otherwise at the scan index.
  assign probe_idx = (state_q == ST_PROBE) ? hint_q : idx_q;

  king_square_match u_match (
    .board_i (board),
    .index_i (probe_idx),
    .color_i (color_q),
    .match_o (sq_match)
  );

  // Next-state and result bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    color_d = color_q;
    hint_d  = hint_q;
    found_d = found_q;
    pos_d   = pos_q;
    multi_d = multi_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          color_d = color;
          hint_d  = hint_pos;
          found_d = 1'b0;
          pos_d   = '0;
          multi_d = 1'b0;
          idx_d   = '0;
          state_d = HINT_FIRST ? ST_PROBE : ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROBE: begin
        idx_d = '0;
        if (sq_match) begin
          found_d = 1'b1;
          pos_d   = hint_q;
          multi_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (sq_match) begin
          // Only "first" vs "another" matters, so found doubles as the saturated count.
          if (!found_q) begin
            found_d = 1'b1;
            pos_d   = idx_q;
          end else begin
            multi_d = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 6'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      color_q <= WHITE;
      hint_q  <= '0;
      found_q <= 1'b0;
      pos_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      color_q <= color_d;
      hint_q  <= hint_d;
      found_q <= found_d;
      pos_q   <= pos_d;
      multi_q <= multi_d;
    end
  end

  assign busy     = (state_q == ST_PROBE) || (state_q == ST_SCAN);
  assign done     = (state_q == ST_DONE);
  assign found    = found_q;
  assign king_pos = pos_q;
  assign multi    = multi_q;

endmodule
